// File: rtl/dbus_ctrl_if.sv
// Data-bus interface between the load/store controller and memory.
// The controller (master) issues single-beat requests and waits for a one-cycle
// ack strobe; the memory (slave) returns read data in that ack cycle.
interface dbus_ctrl_if;
   logic        o_bus_req;
   logic        o_bus_we;
   logic [31:0] o_bus_addr;
   logic [31:0] o_bus_wdata;
   logic        i_bus_ack;
   logic [31:0] i_bus_rdata;

   modport master (
      output o_bus_req,
      output o_bus_we,
      output o_bus_addr,
      output o_bus_wdata,
      input  i_bus_ack,
      input  i_bus_rdata
   );

   modport slave (
      input  o_bus_req,
      input  o_bus_we,
      input  o_bus_addr,
      input  o_bus_wdata,
      output i_bus_ack,
      output i_bus_rdata
   );
endinterface : dbus_ctrl_if

// File: rtl/dbus_ctrl.sv
// Memory-stage data-bus controller.
// Turns a core load/store request into one bus transaction, stalls the whole
// pipeline while the transaction is outstanding, and aborts with a sticky
// error flag if memory does not acknowledge within TIMEOUT busy cycles.
// Sequence: IDLE (request seen) -> BUSY (bus_req high) -> DONE (one cycle,
// stall released, read data presented) -> IDLE.
module dbus_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_read_en,
   input  logic        i_write_en,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_read_vd,
   output logic        o_stall,
   output logic        o_err,
   dbus_ctrl_if.master bus
);

   // Last wait-count value before the abort; with TIMEOUT = N the BUSY state
   // lasts at most N cycles (count runs 0..N-1 and the abort is taken on N-1).
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_r;
   logic [15:0] wait_cnt_r;
   logic        bus_req_r;
   logic        bus_we_r;
   logic [31:0] bus_addr_r;
   logic [31:0] bus_wdata_r;
   logic [31:0] rdata_r;
   logic        read_vd_r;
   logic        err_r;
   logic        core_req_s;

   assign core_req_s = i_read_en | i_write_en;

   // Transaction FSM with all bus/core-facing outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         wait_cnt_r  <= 16'd0;
         bus_req_r   <= 1'b0;
         bus_we_r    <= 1'b0;
         bus_addr_r  <= 32'd0;
         bus_wdata_r <= 32'd0;
         rdata_r     <= 32'd0;
         read_vd_r   <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               read_vd_r <= 1'b0;
               if (core_req_s) begin
                  // A simultaneous read+write is treated as a write.
                  state_r     <= ST_BUSY;
                  bus_req_r   <= 1'b1;
                  bus_we_r    <= i_write_en;
                  bus_addr_r  <= i_addr;
                  bus_wdata_r <= i_wdata;
                  wait_cnt_r  <= 16'd0;
               end else begin
                  state_r   <= ST_IDLE;
                  bus_req_r <= 1'b0;
               end
            end

            ST_BUSY: begin
               if (bus.i_bus_ack) begin
                  // Ack wins over a timeout that would fire in the same cycle.
                  state_r   <= ST_DONE;
                  bus_req_r <= 1'b0;
                  read_vd_r <= ~bus_we_r;
                  if (!bus_we_r) begin
                     rdata_r <= bus.i_bus_rdata;
                  end else begin
                     rdata_r <= rdata_r;
                  end
               end else if (wait_cnt_r >= WAIT_LAST) begin
                  // Abort: complete with zero data and latch the error.
                  state_r   <= ST_DONE;
                  bus_req_r <= 1'b0;
                  read_vd_r <= ~bus_we_r;
                  rdata_r   <= 32'd0;
                  err_r     <= 1'b1;
               end else begin
                  state_r    <= ST_BUSY;
                  wait_cnt_r <= wait_cnt_r + 16'd1;
               end
            end

            ST_DONE: begin
               // The core request is still asserted here; it belongs to the
               // transaction just finished, so never restart from DONE.
               state_r   <= ST_IDLE;
               read_vd_r <= 1'b0;
               bus_req_r <= 1'b0;
            end

            default: begin
               state_r   <= ST_IDLE;
               bus_req_r <= 1'b0;
               read_vd_r <= 1'b0;
            end
         endcase
      end
   end

   // Pipeline stall: hold the core from the request cycle until DONE.
   always_comb begin
      o_stall = 1'b0;
      case (state_r)
         ST_IDLE: o_stall = core_req_s;
         ST_BUSY: o_stall = 1'b1;
         ST_DONE: o_stall = 1'b0;
         default: o_stall = 1'b0;
      endcase
   end

   assign bus.o_bus_req   = bus_req_r;
   assign bus.o_bus_we    = bus_we_r;
   assign bus.o_bus_addr  = bus_addr_r;
   assign bus.o_bus_wdata = bus_wdata_r;
   assign o_rdata         = rdata_r;
   assign o_read_vd       = read_vd_r;
   assign o_err           = err_r;

endmodule : dbus_ctrl

// File: doc/dbus_ctrl.md
DBUS_CTRL -- requirements
Module: dbus_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: max BUSY cycles waiting for i_bus_ack before abort; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_read_en  input  1  core memory-stage load request.
REQ-005 i_write_en  input  1  core memory-stage store request.
REQ-006 i_addr  input  32  core byte address.
REQ-007 i_wdata  input  32  core store data, already lane-aligned.
REQ-008 o_rdata  output  32  load data returned to core.
REQ-009 o_read_vd  output  1  load data valid strobe to core.
REQ-010 o_stall  output  1  external stall to core; freezes the whole pipeline.
REQ-011 o_bus_req  output  1  bus transaction request.
REQ-012 o_bus_we  output  1  1 = write, 0 = read.
REQ-013 o_bus_addr  output  32  bus address.
REQ-014 o_bus_wdata  output  32  bus write data.
REQ-015 i_bus_ack  input  1  one-cycle completion strobe from memory.
REQ-016 i_bus_rdata  input  32  read data, valid only in the i_bus_ack cycle.
REQ-017 o_err  output  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-019 IDLE SHALL go to BUSY when i_read_en or i_write_en is high; otherwise it SHALL stay in IDLE.
REQ-020 On the IDLE->BUSY edge, the block SHALL latch i_addr, i_wdata and we = i_write_en into o_bus_addr, o_bus_wdata and o_bus_we.
REQ-021 If i_read_en and i_write_en are both high, the request SHALL be treated as a write.
REQ-022 o_bus_req SHALL be a register, 1 exactly while in BUSY.
REQ-023 o_bus_addr, o_bus_wdata and o_bus_we SHALL hold stable throughout BUSY.
REQ-024 BUSY SHALL go to DONE on the edge where i_bus_ack = 1. For a read, i_bus_rdata SHALL be captured into o_rdata on that edge.
REQ-025 A wait counter SHALL be cleared on BUSY entry and SHALL increment every BUSY cycle without ack.
REQ-026 When the wait counter reaches TIMEOUT without ack, the block SHALL go to DONE, set o_rdata = 0 and set o_err = 1.
REQ-027 o_err SHALL stay 1 until reset.
REQ-028 DONE SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-029 o_stall SHALL be combinational: 1 when (IDLE and (i_read_en or i_write_en)) or BUSY; 0 in DONE.
REQ-030 The pipeline therefore advances at the end of the DONE cycle; the still-asserted request in DONE SHALL NOT start a new transaction.
REQ-031 o_read_vd SHALL be 1 only in DONE and only when the completed transaction was a read, including a timed-out read.
REQ-032 o_rdata SHALL hold its last value outside DONE.
REQ-033 i_bus_ack SHALL be ignored in IDLE and DONE.
REQ-034 Minimum latency: request cycle 0 (IDLE), ack cycle 1 (BUSY), data and release cycle 2 (DONE); o_stall is high for 2 cycles.
REQ-035 Back-to-back requests: a new request seen in the IDLE cycle right after DONE SHALL start a new transaction with no idle gap beyond that cycle.

Reset
REQ-036 While rst is high at a clock edge, state SHALL become IDLE and o_bus_req, o_bus_we, o_read_vd and o_err SHALL become 0.
REQ-037 Reset SHALL clear o_rdata, o_bus_addr, o_bus_wdata and the wait counter to 0.
REQ-038 Reset during BUSY SHALL abort the transaction and drop o_bus_req on the next edge; a late ack after reset SHALL be ignored.
REQ-039 During reset, o_stall SHALL follow REQ-029 from the reset state.

Verification
REQ-040 Read, immediate ack:
- Stimulus: i_read_en = 1, i_addr = 0x0000_0100; ack in cycle 1 with rdata 0xDEAD_BEEF.
- Response: o_stall high cycles 0-1; cycle 2 has o_read_vd = 1, o_rdata = 0xDEAD_BEEF, o_stall = 0.
REQ-041 Write, 3-cycle ack delay:
- Stimulus: i_write_en = 1, addr 0x200, wdata 0x1234_5678.
- Response: o_bus_req high 4 cycles with addr/wdata stable and o_bus_we = 1; o_read_vd stays 0; o_stall high 5 cycles.
REQ-042 Timeout, TIMEOUT = 4:
- Stimulus: read, no ack.
- Response: BUSY lasts 4 cycles, then DONE with o_rdata = 0, o_read_vd = 1 and o_err = 1; o_err stays 1 through later good transactions.
REQ-043 Back-to-back:
- Stimulus: a load then a store, each acked in its first BUSY cycle.
- Response: two distinct bus transactions, in order; no duplicate request issued in the DONE cycles.
REQ-044 Reset mid-BUSY:
- Stimulus: assert rst in the second BUSY cycle, then ack one cycle later.
- Response: o_bus_req = 0 after the reset edge; the ack is ignored; o_read_vd stays 0; state is IDLE.
REQ-045 Simultaneous read and write enables:
- Stimulus: i_read_en = i_write_en = 1.
- Response: o_bus_we = 1 and o_read_vd = 0 on completion.
